// File: rtl/sd_spi_router_if.sv
// Host-side SPI bus between the core SPI master and sd_spi_router.
// The master modport is the core/host side, the slave modport is the router.
interface sd_spi_router_if #(
    parameter int NUM_SLOTS = 2
);
    logic [NUM_SLOTS-1:0] host_cs_n;
    logic                 host_sck;
    logic                 host_mosi;
    logic                 host_miso;

    modport master (
        output host_cs_n,
        output host_sck,
        output host_mosi,
        input  host_miso
    );

    modport slave (
        input  host_cs_n,
        input  host_sck,
        input  host_mosi,
        output host_miso
    );
endinterface

// File: rtl/sd_spi_router.sv
// sd_spi_router: routes one host SPI master to NUM_SLOTS card slots. Each slot
// is served by a virtual SD image, or (slot 0 only) by the physical SD card.
// Source changes are deferred until the slot's chip select is idle.
// Optional build macro SDR_CD_GATE_EN: gates the slot 0 physical path with the
// synchronised physical card-detect (phy_cd_n).
//
// Per-slot select FSM:
//   state   | meaning
//   SETTLED | vsd_sel matches the last requested source
//   PENDING | a new source is requested, waiting for chip select to go idle
module sd_spi_router #(
    parameter int NUM_SLOTS   = 2,
    parameter int ACT_TIMEOUT = 1000000
) (
    input  logic                 clk_sys,
    input  logic                 RESET,
    input  logic [NUM_SLOTS-1:0] img_mounted,
    input  logic [NUM_SLOTS-1:0] img_size_nz,
    sd_spi_router_if.slave       host,
    output logic [NUM_SLOTS-1:0] vsd_cs_n,
    output logic                 vsd_sck,
    output logic                 vsd_mosi,
    input  logic [NUM_SLOTS-1:0] vsd_miso,
    output logic                 phy_cs_n,
    output logic                 phy_sck,
    output logic                 phy_mosi,
    input  logic                 phy_miso,
    input  logic                 phy_cd_n,
    output logic [NUM_SLOTS-1:0] vsd_sel,
    output logic [NUM_SLOTS-1:0] act,
    output logic                 led_phys
);

    localparam int CW = $clog2(ACT_TIMEOUT + 1);
    localparam logic [CW-1:0] ACT_MAX = CW'(ACT_TIMEOUT);

    typedef enum logic {
        SETTLED = 1'b0,
        PENDING = 1'b1
    } sel_state_e;

    sel_state_e           state_q [NUM_SLOTS];
    sel_state_e           state_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] req_q, req_d;
    logic [NUM_SLOTS-1:0] vsd_sel_q, vsd_sel_d;
    logic [CW-1:0]        cnt_q [NUM_SLOTS];
    logic [CW-1:0]        cnt_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] act_q, act_d;
    logic                 led_phys_q, led_phys_d;
    logic                 mosi_q, mosi_d;
    logic [NUM_SLOTS-1:0] miso_q, miso_d;
    logic [NUM_SLOTS-1:0] slot_miso;
    logic                 phy_ok;

`ifdef SDR_CD_GATE_EN
    logic [1:0] cd_sync_q, cd_sync_d;

    // Card-detect synchroniser; reset to "no card" so the physical path stays closed
    always_comb begin
        cd_sync_d = {cd_sync_q[0], phy_cd_n};
    end

    // Synchroniser flops
    always_ff @(posedge clk_sys) begin
        if (RESET) cd_sync_q <= 2'b11;
        else       cd_sync_q <= cd_sync_d;
    end

    assign phy_ok = ~cd_sync_q[1];
`else
    logic cd_unused;
    assign cd_unused = phy_cd_n;
    assign phy_ok    = 1'b1;
`endif

    // Select FSM next state: mount loads req, switch only when CS is idle
    always_comb begin
        req_d     = req_q;
        vsd_sel_d = vsd_sel_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            state_d[i] = state_q[i];
            if (img_mounted[i]) begin
                // A mount pulse only loads the request; any switch waits a cycle
                req_d[i]   = img_size_nz[i];
                state_d[i] = (img_size_nz[i] != vsd_sel_q[i]) ? PENDING : SETTLED;
            end else if (state_q[i] == PENDING && host.host_cs_n[i]) begin
                vsd_sel_d[i] = req_q[i];
                state_d[i]   = SETTLED;
            end
        end
    end

    // Per-slot miso as seen by the host, and host_miso from the lowest active CS
    always_comb begin
        slot_miso      = '1;
        host.host_miso = 1'b1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (vsd_sel_q[i])           slot_miso[i] = vsd_miso[i];
            else if (i == 0 && phy_ok)  slot_miso[i] = phy_miso;
        end
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!host.host_cs_n[i]) host.host_miso = slot_miso[i];
        end
    end

    // Activity counters: clear on a data edge while selected, else saturate up
    always_comb begin
        mosi_d = host.host_mosi;
        miso_d = slot_miso;
        act_d  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            act_d[i] = (cnt_q[i] < ACT_MAX);
            if (!host.host_cs_n[i] &&
                ((host.host_mosi != mosi_q) || (slot_miso[i] != miso_q[i])))
                cnt_d[i] = '0;
            else if (cnt_q[i] < ACT_MAX)
                cnt_d[i] = cnt_q[i] + 1'b1;
            else
                cnt_d[i] = cnt_q[i];
        end
        led_phys_d = act_q[0] & ~vsd_sel_q[0];
    end

    // State registers
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            req_q      <= '0;
            vsd_sel_q  <= '0;
            act_q      <= '0;
            led_phys_q <= 1'b0;
            mosi_q     <= 1'b0;
            miso_q     <= '1;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= SETTLED;
                cnt_q[i]   <= ACT_MAX;
            end
        end else begin
            req_q      <= req_d;
            vsd_sel_q  <= vsd_sel_d;
            act_q      <= act_d;
            led_phys_q <= led_phys_d;
            mosi_q     <= mosi_d;
            miso_q     <= miso_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Routing driven from the registered source selection
    always_comb begin
        vsd_cs_n = host.host_cs_n | ~vsd_sel_q;
        vsd_sck  = host.host_sck;
        vsd_mosi = host.host_mosi;
        phy_cs_n = host.host_cs_n[0] | vsd_sel_q[0] | ~phy_ok;
        phy_sck  = host.host_sck & ~vsd_sel_q[0];
        phy_mosi = host.host_mosi & ~vsd_sel_q[0];
        vsd_sel  = vsd_sel_q;
        act      = act_q;
        led_phys = led_phys_q;
    end

endmodule

// File: tb/tb_sd_spi_router.sv
// Directed testbench for sd_spi_router (NUM_SLOTS=2, ACT_TIMEOUT=16).
module tb_sd_spi_router;

    localparam int NS = 2;

    logic          clk_sys = 1'b0;
    logic          RESET;
    logic [NS-1:0] img_mounted, img_size_nz;
    logic [NS-1:0] vsd_cs_n, vsd_miso, vsd_sel, act;
    logic          vsd_sck, vsd_mosi;
    logic          phy_cs_n, phy_sck, phy_mosi, phy_miso, phy_cd_n, led_phys;

    int checks = 0;
    int errors = 0;

    sd_spi_router_if #(.NUM_SLOTS(NS)) host_if ();

    sd_spi_router #(.NUM_SLOTS(NS), .ACT_TIMEOUT(16)) dut (
        .clk_sys     (clk_sys),
        .RESET       (RESET),
        .img_mounted (img_mounted),
        .img_size_nz (img_size_nz),
        .host        (host_if),
        .vsd_cs_n    (vsd_cs_n),
        .vsd_sck     (vsd_sck),
        .vsd_mosi    (vsd_mosi),
        .vsd_miso    (vsd_miso),
        .phy_cs_n    (phy_cs_n),
        .phy_sck     (phy_sck),
        .phy_mosi    (phy_mosi),
        .phy_miso    (phy_miso),
        .phy_cd_n    (phy_cd_n),
        .vsd_sel     (vsd_sel),
        .act         (act),
        .led_phys    (led_phys)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        img_mounted = '0; img_size_nz = '0;
        host_if.host_cs_n = 2'b11; host_if.host_sck = 1'b0; host_if.host_mosi = 1'b0;
        vsd_miso = '0; phy_miso = 1'b0; phy_cd_n = 1'b0;
        repeat (3) step();
        RESET = 1'b0;
        repeat (4) step();
        checks++; if (vsd_sel !== 2'b00) begin errors++; $display("FAIL reset_vsd_sel got=%b exp=00", vsd_sel); end
        checks++; if (act !== 2'b00) begin errors++; $display("FAIL reset_act got=%b exp=00", act); end
        checks++; if (led_phys !== 1'b0) begin errors++; $display("FAIL reset_led got=%b exp=0", led_phys); end
        checks++; if (phy_cs_n !== 1'b1) begin errors++; $display("FAIL reset_phy_cs_n got=%b exp=1", phy_cs_n); end
        checks++; if (vsd_cs_n !== 2'b11) begin errors++; $display("FAIL reset_vsd_cs_n got=%b exp=11", vsd_cs_n); end
        checks++; if (host_if.host_miso !== 1'b1) begin errors++; $display("FAIL reset_host_miso got=%b exp=1", host_if.host_miso); end
    endtask

    task automatic test_phys_path();
        host_if.host_cs_n = 2'b10;
        #1;
        checks++; if (phy_cs_n !== 1'b0) begin errors++; $display("FAIL phys_cs_n got=%b exp=0", phy_cs_n); end
        checks++; if (vsd_cs_n !== 2'b11) begin errors++; $display("FAIL phys_vsd_cs_n got=%b exp=11", vsd_cs_n); end
        host_if.host_sck = 1'b1;
        #1;
        checks++; if (phy_sck !== 1'b1) begin errors++; $display("FAIL phys_sck got=%b exp=1", phy_sck); end
        checks++; if (vsd_sck !== 1'b1) begin errors++; $display("FAIL vsd_sck got=%b exp=1", vsd_sck); end
        checks++; if (host_if.host_miso !== 1'b0) begin errors++; $display("FAIL phys_miso got=%b exp=0", host_if.host_miso); end
        host_if.host_sck = 1'b0;
        host_if.host_mosi = 1'b1;
        #1;
        checks++; if (phy_mosi !== 1'b1) begin errors++; $display("FAIL phys_mosi got=%b exp=1", phy_mosi); end
        step();
        checks++; if (act[0] !== 1'b0) begin errors++; $display("FAIL act_latency0 got=%b exp=0", act[0]); end
        step();
        checks++; if (act[0] !== 1'b1) begin errors++; $display("FAIL act_latency1 got=%b exp=1", act[0]); end
        checks++; if (led_phys !== 1'b0) begin errors++; $display("FAIL led_latency0 got=%b exp=0", led_phys); end
        step();
        checks++; if (led_phys !== 1'b1) begin errors++; $display("FAIL led_latency1 got=%b exp=1", led_phys); end
    endtask

    // One toggle at edge 1, optional second toggle taking effect at edge 11
    task automatic measure_act(input bit retoggle, input int exp_cnt, input string name);
        int  cnt;
        bit  idle;
        idle = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (act[0] === 1'b0) begin idle = 1'b1; break; end
        end
        checks++; if (!idle) begin errors++; $display("FAIL %s_idle_timeout got=%b exp=0", name, act[0]); end
        host_if.host_mosi = ~host_if.host_mosi;
        step();
        cnt = 0;
        for (int k = 2; k < 80; k++) begin
            step();
            if (act[0] === 1'b1) cnt++;
            if (retoggle && k == 10) host_if.host_mosi = ~host_if.host_mosi;
        end
        checks++; if (cnt != exp_cnt) begin errors++; $display("FAIL %s got=%0d exp=%0d", name, cnt, exp_cnt); end
    endtask

    task automatic test_act_timeout();
        measure_act(1'b0, 16, "act_window");
        measure_act(1'b1, 26, "act_restart");
    endtask

    task automatic test_mount_idle();
        host_if.host_cs_n = 2'b11;
        step();
        img_mounted = 2'b10; img_size_nz = 2'b10;
        step();
        img_mounted = 2'b00; img_size_nz = 2'b00;
        checks++; if (vsd_sel !== 2'b00) begin errors++; $display("FAIL mount_n1 got=%b exp=00", vsd_sel); end
        step();
        checks++; if (vsd_sel !== 2'b10) begin errors++; $display("FAIL mount_n2 got=%b exp=10", vsd_sel); end
        host_if.host_cs_n = 2'b01;
        vsd_miso = 2'b10;
        #1;
        checks++; if (vsd_cs_n !== 2'b01) begin errors++; $display("FAIL slot1_vsd_cs_n got=%b exp=01", vsd_cs_n); end
        checks++; if (phy_cs_n !== 1'b1) begin errors++; $display("FAIL slot1_phy_cs_n got=%b exp=1", phy_cs_n); end
        checks++; if (host_if.host_miso !== 1'b1) begin errors++; $display("FAIL slot1_miso_hi got=%b exp=1", host_if.host_miso); end
        vsd_miso = 2'b00;
        #1;
        checks++; if (host_if.host_miso !== 1'b0) begin errors++; $display("FAIL slot1_miso_lo got=%b exp=0", host_if.host_miso); end
        host_if.host_cs_n = 2'b11;
        step();
    endtask

    task automatic test_mount_busy();
        int bad_sel, bad_cs;
        host_if.host_cs_n = 2'b10;
        step();
        img_mounted = 2'b01; img_size_nz = 2'b01;
        step();
        img_mounted = 2'b00; img_size_nz = 2'b00;
        bad_sel = 0; bad_cs = 0;
        for (int k = 0; k < 500; k++) begin
            step();
            if (vsd_sel[0] !== 1'b0) bad_sel++;
            if (phy_cs_n !== 1'b0) bad_cs++;
        end
        checks++; if (bad_sel != 0) begin errors++; $display("FAIL busy_hold_sel bad_cycles=%0d exp=0", bad_sel); end
        checks++; if (bad_cs != 0) begin errors++; $display("FAIL busy_phy_cs_glitch bad_cycles=%0d exp=0", bad_cs); end
        host_if.host_cs_n = 2'b11;
        #1;
        checks++; if (vsd_sel[0] !== 1'b0) begin errors++; $display("FAIL busy_pre_edge got=%b exp=0", vsd_sel[0]); end
        step();
        checks++; if (vsd_sel !== 2'b11) begin errors++; $display("FAIL busy_switch got=%b exp=11", vsd_sel); end
        checks++; if (phy_cs_n !== 1'b1) begin errors++; $display("FAIL busy_phy_cs_after got=%b exp=1", phy_cs_n); end
    endtask

    task automatic test_reset_mid();
        host_if.host_cs_n = 2'b10;
        step();
        checks++; if (vsd_cs_n !== 2'b10) begin errors++; $display("FAIL mid_pre_vsd_cs_n got=%b exp=10", vsd_cs_n); end
        RESET = 1'b1;
        step();
        checks++; if (vsd_sel !== 2'b00) begin errors++; $display("FAIL mid_reset_sel got=%b exp=00", vsd_sel); end
        checks++; if (vsd_cs_n !== 2'b11) begin errors++; $display("FAIL mid_reset_vsd_cs_n got=%b exp=11", vsd_cs_n); end
        RESET = 1'b0;
        host_if.host_cs_n = 2'b11;
        repeat (4) step();
    endtask

    task automatic test_unmount_pending();
        int bad;
        host_if.host_cs_n = 2'b10;
        step();
        img_mounted = 2'b01; img_size_nz = 2'b01;
        step();
        img_mounted = 2'b00; img_size_nz = 2'b00;
        repeat (5) step();
        img_mounted = 2'b01; img_size_nz = 2'b00;
        step();
        img_mounted = 2'b00;
        repeat (3) step();
        host_if.host_cs_n = 2'b11;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (vsd_sel[0] !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL unmount_pending bad_cycles=%0d exp=0", bad); end
    endtask

    task automatic test_cd_gate();
        phy_cd_n = 1'b1;
        phy_miso = 1'b0;
        repeat (3) step();
        host_if.host_cs_n = 2'b10;
        #1;
`ifdef SDR_CD_GATE_EN
        checks++; if (phy_cs_n !== 1'b1) begin errors++; $display("FAIL cd_gate_cs got=%b exp=1", phy_cs_n); end
        checks++; if (host_if.host_miso !== 1'b1) begin errors++; $display("FAIL cd_gate_miso got=%b exp=1", host_if.host_miso); end
        phy_cd_n = 1'b0;
        step();
        checks++; if (phy_cs_n !== 1'b1) begin errors++; $display("FAIL cd_sync1 got=%b exp=1", phy_cs_n); end
        step();
        checks++; if (phy_cs_n !== 1'b0) begin errors++; $display("FAIL cd_sync2 got=%b exp=0", phy_cs_n); end
        checks++; if (host_if.host_miso !== 1'b0) begin errors++; $display("FAIL cd_open_miso got=%b exp=0", host_if.host_miso); end
`else
        checks++; if (phy_cs_n !== 1'b0) begin errors++; $display("FAIL cd_ignored_cs got=%b exp=0", phy_cs_n); end
        checks++; if (host_if.host_miso !== 1'b0) begin errors++; $display("FAIL cd_ignored_miso got=%b exp=0", host_if.host_miso); end
        phy_cd_n = 1'b0;
`endif
        host_if.host_cs_n = 2'b11;
        step();
    endtask

    initial begin
        test_reset();
        test_phys_path();
        test_act_timeout();
        test_mount_idle();
        test_mount_busy();
        test_reset_mid();
        test_unmount_pending();
        test_cd_gate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
